// File: rtl/vm1_bus_pkg.sv
// Purpose : shared definitions for the vm1 Q-bus cycle sequencer / DMA arbiter.
// Latency : n/a (types, constants and a helper only).
// Backpres: n/a.
// Contents: 3-bit state encoding, default timeout, strobe-bundle bit positions
//           (also the field layout of the test_bus debug vector).
package vm1_bus_pkg;

   localparam int unsigned BUS_TIMEOUT_DEF = 63;
   localparam int unsigned TMO_W_DEF       = 6;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_READ       = 3'd1,
      ST_WRITE      = 3'd2,
      ST_FINISH     = 3'd3,
      ST_BUSERR     = 3'd4,
      ST_DMA_OFFER  = 3'd5,
      ST_DMA_ACTIVE = 3'd6
   } qbus_state_t;

   // Strobe-bundle field positions.
   localparam int SB_SYNC = 0;
   localparam int SB_DIN  = 1;
   localparam int SB_DOUT = 2;
   localparam int SB_WTBT = 3;
   localparam int SB_DONE = 4;
   localparam int SB_BERR = 5;
   localparam int SB_DMGO = 6;
   localparam int SB_DMA  = 7;
   localparam int STRB_W  = 8;

   typedef logic [STRB_W-1:0] strb_t;

   // Strobes driven while a CPU bus cycle is in its address/data phase.
   function automatic strb_t strb_cycle(input logic rd, input logic wr, input logic byt);
      strb_t s;
      s          = '0;
      s[SB_SYNC] = 1'b1;
      s[SB_DIN]  = rd;
      s[SB_DOUT] = wr;
      s[SB_WTBT] = byt;
      return s;
   endfunction

endpackage

// File: rtl/qbus_timeout_ctr.sv
// Purpose : reply-timeout down-counter with load, decrement and zero flag.
// Latency : load/decrement take effect on the next ce-qualified clk edge.
// Backpres: none; ce=0 freezes the count.
// Ports   : clk, reset (sync, active-high), ce, load, dec in; zero out.
module qbus_timeout_ctr #(
   parameter int unsigned W    = 6,
   parameter int unsigned INIT = 63
) (
   input  logic clk,
   input  logic reset,
   input  logic ce,
   input  logic load,
   input  logic dec,
   output logic zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= W'(INIT);
      end else if (ce) begin
         if (load) begin
            cnt <= W'(INIT);
         end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/qbus_arbiter.sv
// Purpose : Q-bus cycle sequencer (SYNC/DIN/DOUT/WTBT from CPU requests, waits RPLY)
//           plus DMA arbitration (DMR/DMGO/SACK) between CPU cycles.
// Latency : request to cpu_done min 3 ce cycles; all outputs registered.
// Backpres: CPU requests are level-held and stall while DMA owns the bus or RPLY is pending.
// Ports   : clk, reset, ce; cpu_dati/cpu_dato/cpu_byte in, cpu_done/cpu_berror out;
//           breply in, bsync/bdin/bdout/bwtbt/bbsy out; dmr/sack in, dmgo/dma_active out.
// Config  : QBUS_TIMEOUT_EN enables the reply timeout counter and the BUSERR path.
module qbus_arbiter
   import vm1_bus_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = BUS_TIMEOUT_DEF,
   parameter int unsigned TMO_W       = TMO_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic ce,
   input  logic cpu_dati,
   input  logic cpu_dato,
   input  logic cpu_byte,
   output logic cpu_done,
   output logic cpu_berror,
   input  logic breply,
   output logic bsync,
   output logic bdin,
   output logic bdout,
   output logic bwtbt,
   output logic bbsy,
   input  logic dmr,
   output logic dmgo,
   input  logic sack,
   output logic dma_active
);

   // Out-of-range timeout settings stop elaboration.
   if ((BUS_TIMEOUT < 1) || (BUS_TIMEOUT > (1 << TMO_W) - 1)) begin : g_bad_timeout
      $error("qbus_arbiter: BUS_TIMEOUT does not fit in TMO_W bits");
   end

   qbus_state_t state_q, state_d;
   strb_t       strb_q, strb_d;

`ifdef QBUS_TIMEOUT_EN
   logic ctr_load, ctr_dec, ctr_zero;

   qbus_timeout_ctr #(
      .W    (TMO_W),
      .INIT (BUS_TIMEOUT)
   ) u_tmo (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .load  (ctr_load),
      .dec   (ctr_dec),
      .zero  (ctr_zero)
   );
`endif

   // Next state and next (registered) outputs; outputs default low.
   always_comb begin
      state_d = state_q;
      strb_d  = '0;
`ifdef QBUS_TIMEOUT_EN
      ctr_load = 1'b0;
      ctr_dec  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            // DMA wins over a simultaneous CPU request; read wins over write.
            if (dmr) begin
               state_d          = ST_DMA_OFFER;
               strb_d[SB_DMGO]  = 1'b1;
            end else if (cpu_dati) begin
               state_d = ST_READ;
               strb_d  = strb_cycle(1'b1, 1'b0, cpu_byte);
`ifdef QBUS_TIMEOUT_EN
               ctr_load = 1'b1;
`endif
            end else if (cpu_dato) begin
               state_d = ST_WRITE;
               strb_d  = strb_cycle(1'b0, 1'b1, cpu_byte);
`ifdef QBUS_TIMEOUT_EN
               ctr_load = 1'b1;
`endif
            end
         end
         ST_READ, ST_WRITE: begin
            if (breply) begin
               state_d         = ST_FINISH;
               strb_d[SB_DONE] = 1'b1;
`ifdef QBUS_TIMEOUT_EN
            end else if (ctr_zero) begin
               state_d         = ST_BUSERR;
               strb_d[SB_BERR] = 1'b1;
`endif
            end else begin
               // Hold strobes; WTBT keeps the value latched at cycle entry.
               strb_d = strb_q;
`ifdef QBUS_TIMEOUT_EN
               ctr_dec = 1'b1;
`endif
            end
         end
         ST_FINISH: begin
            // Wait for RPLY to drop before another SYNC may start.
            if (!breply) state_d = ST_IDLE;
         end
         ST_BUSERR: begin
            state_d = ST_IDLE;
         end
         ST_DMA_OFFER: begin
            if (sack) begin
               state_d         = ST_DMA_ACTIVE;
               strb_d[SB_DMA]  = 1'b1;
            end else if (!dmr) begin
               state_d = ST_IDLE;
            end else begin
               strb_d[SB_DMGO] = 1'b1;
            end
         end
         ST_DMA_ACTIVE: begin
            if (sack) strb_d[SB_DMA] = 1'b1;
            else      state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         strb_q  <= '0;
      end else if (ce) begin
         state_q <= state_d;
         strb_q  <= strb_d;
      end
   end

   assign bsync      = strb_q[SB_SYNC];
   assign bbsy       = strb_q[SB_SYNC];
   assign bdin       = strb_q[SB_DIN];
   assign bdout      = strb_q[SB_DOUT];
   assign bwtbt      = strb_q[SB_WTBT];
   assign cpu_done   = strb_q[SB_DONE];
   assign dmgo       = strb_q[SB_DMGO];
   assign dma_active = strb_q[SB_DMA];
`ifdef QBUS_TIMEOUT_EN
   assign cpu_berror = strb_q[SB_BERR];
`else
   assign cpu_berror = 1'b0;
`endif

endmodule

// File: tb/tb_qbus_arbiter.sv
// Purpose : directed self-checking bench for qbus_arbiter (timeout build or not).
// Latency : inputs driven 1ns after posedge, outputs sampled at the same point.
// Backpres: n/a.
module tb_qbus_arbiter;

   logic clk = 1'b0;
   logic reset, ce;
   logic cpu_dati, cpu_dato, cpu_byte, cpu_done, cpu_berror;
   logic breply, bsync, bdin, bdout, bwtbt, bbsy;
   logic dmr, dmgo, sack, dma_active;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   qbus_arbiter #(
      .BUS_TIMEOUT (4),
      .TMO_W       (6)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ce         (ce),
      .cpu_dati   (cpu_dati),
      .cpu_dato   (cpu_dato),
      .cpu_byte   (cpu_byte),
      .cpu_done   (cpu_done),
      .cpu_berror (cpu_berror),
      .breply     (breply),
      .bsync      (bsync),
      .bdin       (bdin),
      .bdout      (bdout),
      .bwtbt      (bwtbt),
      .bbsy       (bbsy),
      .dmr        (dmr),
      .dmgo       (dmgo),
      .sack       (sack),
      .dma_active (dma_active)
   );

   // Observed bundle: {bbsy, dma_active, dmgo, berr, done, wtbt, dout, din, sync}
   function automatic logic [8:0] ex(input logic sy, input logic di, input logic dou,
                                     input logic wt, input logic dn, input logic be,
                                     input logic dg, input logic da);
      return {sy, da, dg, be, dn, wt, dou, di, sy};
   endfunction

   function automatic logic [8:0] obs();
      return {bbsy, dma_active, dmgo, cpu_berror, cpu_done, bwtbt, bdout, bdin, bsync};
   endfunction

   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [8:0] NONE = 9'b0;

   // Reply, cpu_done pulse, FINISH hold while RPLY high, then back to IDLE.
   task automatic finish_cycle(input string tag);
      breply = 1'b1;
      tick();
      check({tag, "_done"}, obs(), ex(0,0,0,0,1,0,0,0));
      cpu_dati = 1'b0;
      cpu_dato = 1'b0;
      tick();
      check({tag, "_fin_hold"}, obs(), NONE);
      breply = 1'b0;
      tick();
      check({tag, "_idle"}, obs(), NONE);
   endtask

   initial begin
      reset = 1'b1; ce = 1'b1;
      cpu_dati = 0; cpu_dato = 0; cpu_byte = 0;
      breply = 0; dmr = 0; sack = 0;
      tick();
      tick();
      check("reset", obs(), NONE);
      reset = 1'b0;
      tick();
      check("idle_after_reset", obs(), NONE);

      // Read, RPLY two cycles after SYNC: SYNC/DIN high for 3 cycles.
      cpu_dati = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rd_sync%0d", i), obs(), ex(1,1,0,0,0,0,0,0));
      end
      finish_cycle("rd");

      // Byte write; WTBT stays latched while cpu_byte toggles.
      cpu_dato = 1'b1; cpu_byte = 1'b1;
      tick();
      check("wrb_entry", obs(), ex(1,0,1,1,0,0,0,0));
      cpu_byte = 1'b0;
      tick();
      check("wrb_wtbt_held", obs(), ex(1,0,1,1,0,0,0,0));
      finish_cycle("wrb");

      // Both requests: read wins.
      cpu_dati = 1'b1; cpu_dato = 1'b1;
      tick();
      check("rd_over_wr", obs(), ex(1,1,0,0,0,0,0,0));
      finish_cycle("rdwr");

`ifdef QBUS_TIMEOUT_EN
      // No reply, BUS_TIMEOUT=4: berror 6 ce cycles after the request.
      cpu_dati = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("tmo_wait%0d", i), obs(), ex(1,1,0,0,0,0,0,0));
      end
      tick();
      check("tmo_berror", obs(), ex(0,0,0,0,0,1,0,0));
      cpu_dati = 1'b0;
      breply   = 1'b1;
      tick();
      check("tmo_late_rply1", obs(), NONE);
      tick();
      check("tmo_late_rply2", obs(), NONE);
      breply = 1'b0;
      tick();
`else
      // No reply and no timeout: SYNC held indefinitely.
      cpu_dati = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         check($sformatf("notmo_hold%0d", i), obs(), ex(1,1,0,0,0,0,0,0));
      end
      finish_cycle("notmo");
`endif

      // ce low for 5 cycles mid-read: outputs and counter frozen.
      cpu_dati = 1'b1;
      tick();
      check("ce_rd1", obs(), ex(1,1,0,0,0,0,0,0));
      tick();
      check("ce_rd2", obs(), ex(1,1,0,0,0,0,0,0));
      ce = 1'b0;
      for (int i = 0; i < 5; i++) begin
         breply = (i >= 1 && i <= 3);
         tick();
         check($sformatf("ce_frozen%0d", i), obs(), ex(1,1,0,0,0,0,0,0));
      end
      breply = 1'b0;
      ce = 1'b1;
`ifdef QBUS_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("ce_resume%0d", i), obs(), ex(1,1,0,0,0,0,0,0));
      end
      tick();
      check("ce_berror", obs(), ex(0,0,0,0,0,1,0,0));
      ce = 1'b0;
      tick();
      check("ce_berror_stretch", obs(), ex(0,0,0,0,0,1,0,0));
      ce = 1'b1;
      cpu_dati = 1'b0;
      tick();
      check("ce_berror_end", obs(), NONE);
`else
      tick();
      check("ce_resume", obs(), ex(1,1,0,0,0,0,0,0));
      finish_cycle("ce");
`endif

      // DMA and read requested together: DMA first, read afterwards.
      dmr = 1'b1; cpu_dati = 1'b1;
      tick();
      check("dma_offer", obs(), ex(0,0,0,0,0,0,1,0));
      tick();
      check("dma_offer_hold", obs(), ex(0,0,0,0,0,0,1,0));
      sack = 1'b1;
      tick();
      check("dma_active", obs(), ex(0,0,0,0,0,0,0,1));
      dmr = 1'b0;
      tick();
      check("dma_active_hold", obs(), ex(0,0,0,0,0,0,0,1));
      sack = 1'b0;
      tick();
      check("dma_release", obs(), NONE);
      tick();
      check("dma_then_read", obs(), ex(1,1,0,0,0,0,0,0));
      finish_cycle("dmard");

      // DMR withdrawn before SACK, then a normal write.
      dmr = 1'b1;
      tick();
      check("wd_offer", obs(), ex(0,0,0,0,0,0,1,0));
      dmr = 1'b0;
      tick();
      check("wd_withdrawn", obs(), NONE);
      cpu_dato = 1'b1; cpu_byte = 1'b0;
      tick();
      check("wd_write", obs(), ex(1,0,1,0,0,0,0,0));
      finish_cycle("wdwr");

      // Reset during a write (with ce low) drops every strobe.
      cpu_dato = 1'b1;
      tick();
      check("rst_wr", obs(), ex(1,0,1,0,0,0,0,0));
      reset = 1'b1; ce = 1'b0;
      tick();
      check("rst_mid_wr", obs(), NONE);
      reset = 1'b0; ce = 1'b1; cpu_dato = 1'b0;
      tick();
      check("rst_idle", obs(), NONE);
      cpu_dati = 1'b1;
      tick();
      check("rst_then_read", obs(), ex(1,1,0,0,0,0,0,0));
      finish_cycle("rstrd");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
